// File: rtl/uart_txq_if.sv
// Host-side bundle of the queued UART transmitter: enqueue strobe, control and status.
// uart_we is a one-cycle strobe with no ready: full advertises backpressure, and a
// write while full is dropped and latched in ovf. No other handshake applies.
interface uart_txq_if #(
   parameter int FIFO_DEPTH = 16
) ();
   logic [7:0]                  wr_data;
   logic                        uart_we;
   logic                        parity_odd;
   logic                        ovf_clr;
   logic                        uart_tx;
   logic                        busy;
   logic                        full;
   logic [$clog2(FIFO_DEPTH):0] level;
   logic                        ovf;
   logic [2:0]                  state;

   modport master (
      output wr_data, uart_we, parity_odd, ovf_clr,
      input  uart_tx, busy, full, level, ovf, state
   );

   modport slave (
      input  wr_data, uart_we, parity_odd, ovf_clr,
      output uart_tx, busy, full, level, ovf, state
   );
endinterface

// File: rtl/uart_txq.sv
// Queued UART transmitter: FIFO, fractional baud accumulator and framing FSM.
// Parity generation is compiled in when UART_TXQ_PARITY_EN is defined.
`ifndef SYSCLK_FREQ
`define SYSCLK_FREQ 50000000
`endif
`ifndef BAUD_RATE
`define BAUD_RATE 115200
`endif

module uart_txq #(
   parameter int DATA_BITS   = 8,
   parameter int STOP_BITS   = 2,
   parameter int FIFO_DEPTH  = 16,
   parameter int SYSCLK_FREQ = `SYSCLK_FREQ,
   parameter int BAUD_RATE   = `BAUD_RATE
) (
   input logic       clk,
   input logic       rst_n,
   uart_txq_if.slave bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
   localparam logic          STOP_LAST = (STOP_BITS == 2);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_STOP   = 3'd3
`ifdef UART_TXQ_PARITY_EN
      , S_PARITY = 3'd4
`endif
   } state_e;

   logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]        level_q, level_d;
   logic                 ovf_q;
   logic [31:0]          acc_q, acc_d;
   logic [32:0]          acc_sum;
   logic                 tick;
   state_e               state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d, head;
   logic [BW-1:0]        bit_q, bit_d;
   logic                 stop_q, stop_d;
   logic                 tx_q, tx_d;
   logic                 push, drop, pop, load, full;
`ifdef UART_TXQ_PARITY_EN
   logic                 par_q, par_d;
`endif

   // The 33-bit sum keeps the threshold compare exact; the 32-bit update wraps correctly.
   assign acc_sum = {1'b0, acc_q} + 33'(BAUD_RATE);
   assign tick    = (acc_sum >= 33'(SYSCLK_FREQ));
   assign acc_d   = tick ? (acc_q + 32'(BAUD_RATE) - 32'(SYSCLK_FREQ))
                         : (acc_q + 32'(BAUD_RATE));

   assign full    = (level_q == LW'(FIFO_DEPTH));
   assign push    = rst_n && bus.uart_we && !full;
   assign drop    = rst_n && bus.uart_we && full;
   assign head    = mem_q[rd_ptr_q];
   assign level_d = level_q + LW'(push) - LW'(pop);

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      bit_d   = bit_q;
      stop_d  = stop_q;
      tx_d    = tx_q;
      load    = 1'b0;
      pop     = 1'b0;
`ifdef UART_TXQ_PARITY_EN
      par_d   = par_q;
`endif
      if (tick) begin
         case (state_q)
            S_IDLE: load = (level_q != '0);
            S_START: begin
               tx_d    = shift_q[0];
               shift_d = shift_q >> 1;
               bit_d   = '0;
               state_d = S_DATA;
            end
            S_DATA: begin
               if (bit_q == BIT_LAST) begin
`ifdef UART_TXQ_PARITY_EN
                  tx_d    = par_q;
                  state_d = S_PARITY;
`else
                  tx_d    = 1'b1;
                  stop_d  = 1'b0;
                  state_d = S_STOP;
`endif
               end else begin
                  tx_d    = shift_q[0];
                  shift_d = shift_q >> 1;
                  bit_d   = bit_q + 1'b1;
               end
            end
`ifdef UART_TXQ_PARITY_EN
            S_PARITY: begin
               tx_d    = 1'b1;
               stop_d  = 1'b0;
               state_d = S_STOP;
            end
`endif
            S_STOP: begin
               if (stop_q == STOP_LAST) begin
                  // Chain straight into the next frame when more bytes are queued.
                  if (level_q != '0) begin
                     load = 1'b1;
                  end else begin
                     tx_d    = 1'b1;
                     state_d = S_IDLE;
                  end
               end else begin
                  stop_d = stop_q + 1'b1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
      if (load) begin
         pop     = 1'b1;
         shift_d = head;
         tx_d    = 1'b0;
         state_d = S_START;
`ifdef UART_TXQ_PARITY_EN
         par_d   = (^head) ^ bus.parity_odd;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ovf_q    <= 1'b0;
         state_q  <= S_IDLE;
         shift_q  <= '0;
         bit_q    <= '0;
         stop_q   <= 1'b0;
         tx_q     <= 1'b1;
`ifdef UART_TXQ_PARITY_EN
         par_q    <= 1'b0;
`endif
      end else begin
         acc_q   <= acc_d;
         level_q <= level_d;
         state_q <= state_d;
         shift_q <= shift_d;
         bit_q   <= bit_d;
         stop_q  <= stop_d;
         tx_q    <= tx_d;
`ifdef UART_TXQ_PARITY_EN
         par_q   <= par_d;
`endif
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         // A dropped write wins over a simultaneous clear.
         if (drop)             ovf_q <= 1'b1;
         else if (bus.ovf_clr) ovf_q <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= bus.wr_data[DATA_BITS-1:0];
   end

   assign bus.uart_tx = tx_q;
   assign bus.busy    = (state_q != S_IDLE);
   assign bus.full    = full;
   assign bus.level   = level_q;
   assign bus.ovf     = ovf_q;
   assign bus.state   = state_q;
endmodule

// File: tb/tb_uart_txq.sv
// Directed bench for uart_txq with SYSCLK_FREQ=10, BAUD_RATE=1 (tick every 10th cycle).
// Cycle 0 is the first cycle after a reset edge; bits are sampled mid-bit.
module tb_uart_txq;
`ifdef UART_TXQ_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int NA = 1 + 8 + P + 2;
   localparam int NB = 1 + 5 + P + 1;

   logic clk = 1'b0;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;

   uart_txq_if #(.FIFO_DEPTH(4)) a_if ();
   uart_txq_if #(.FIFO_DEPTH(4)) b_if ();

   uart_txq #(.DATA_BITS(8), .STOP_BITS(2), .FIFO_DEPTH(4), .SYSCLK_FREQ(10), .BAUD_RATE(1))
      u_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
   uart_txq #(.DATA_BITS(5), .STOP_BITS(1), .FIFO_DEPTH(4), .SYSCLK_FREQ(10), .BAUD_RATE(1))
      u_b (.clk(clk), .rst_n(rst_n), .bus(b_if));

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
      cyc += n;
   endtask

   task automatic step_to(input int c);
      while (cyc < c) step(1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step(1);
      rst_n = 1'b1;
      a_if.uart_we = 1'b0;
      b_if.uart_we = 1'b0;
      cyc = 0;
   endtask

   // Expected line value of bit idx in a frame carrying byte b with nd data bits.
   function automatic logic exp_bit(input logic [7:0] b, input int nd, input logic podd,
                                    input int idx);
      logic par;
      if (idx == 0) return 1'b0;
      if (idx <= nd) return b[idx-1];
      if (P == 1 && idx == nd + 1) begin
         par = podd;
         for (int i = 0; i < nd; i++) par ^= b[i];
         return par;
      end
      return 1'b1;
   endfunction

   task automatic test_reset();
      a_if.uart_we = 1'b1;
      a_if.wr_data = 8'h5A;
      b_if.uart_we = 1'b1;
      b_if.wr_data = 8'h11;
      do_reset();
      checks++; if (a_if.uart_tx !== 1'b1) begin errors++; $display("FAIL reset_tx_a: got %b expected 1", a_if.uart_tx); end
      checks++; if (a_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy_a: got %b expected 0", a_if.busy); end
      checks++; if (a_if.full !== 1'b0) begin errors++; $display("FAIL reset_full_a: got %b expected 0", a_if.full); end
      checks++; if (a_if.level !== 3'd0) begin errors++; $display("FAIL reset_level_a: got %0d expected 0", a_if.level); end
      checks++; if (a_if.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf_a: got %b expected 0", a_if.ovf); end
      checks++; if (b_if.uart_tx !== 1'b1) begin errors++; $display("FAIL reset_tx_b: got %b expected 1", b_if.uart_tx); end
      checks++; if (b_if.level !== 3'd0) begin errors++; $display("FAIL reset_level_b: got %0d expected 0", b_if.level); end
      step(3);
      checks++; if (a_if.level !== 3'd0) begin errors++; $display("FAIL reset_idle_level: got %0d expected 0", a_if.level); end
   endtask

   task automatic test_frame(input logic podd);
      logic e;
      do_reset();
      a_if.parity_odd = podd;
      step_to(1);
      a_if.uart_we = 1'b1;
      a_if.wr_data = 8'h55;
      step(1);
      a_if.uart_we = 1'b0;
      checks++; if (a_if.level !== 3'd1) begin errors++; $display("FAIL frame_level: got %0d expected 1", a_if.level); end
      step_to(9);
      checks++; if (a_if.busy !== 1'b0) begin errors++; $display("FAIL frame_busy_c9: got %b expected 0", a_if.busy); end
      step_to(10);
      checks++; if (a_if.busy !== 1'b1 || a_if.uart_tx !== 1'b0) begin errors++; $display("FAIL frame_start_c10: got busy=%b tx=%b expected busy=1 tx=0", a_if.busy, a_if.uart_tx); end
      for (int k = 0; k < NA; k++) begin
         step_to(15 + 10 * k);
         e = exp_bit(8'h55, 8, podd, k);
         checks++; if (a_if.uart_tx !== e) begin errors++; $display("FAIL frame_p%0d_bit%0d: got %b expected %b", podd, k, a_if.uart_tx, e); end
      end
      step_to(10 * NA + 9);
      checks++; if (a_if.busy !== 1'b1) begin errors++; $display("FAIL frame_busy_last: got %b expected 1", a_if.busy); end
      step(1);
      checks++; if (a_if.busy !== 1'b0 || a_if.uart_tx !== 1'b1) begin errors++; $display("FAIL frame_end: got busy=%b tx=%b expected busy=0 tx=1", a_if.busy, a_if.uart_tx); end
      step(25);
      checks++; if (a_if.uart_tx !== 1'b1) begin errors++; $display("FAIL frame_idle: got %b expected 1", a_if.uart_tx); end
      a_if.parity_odd = 1'b0;
   endtask

   task automatic test_overflow();
      logic [7:0] bytes [7];
      logic       e;
      bytes = '{8'hA1, 8'h3C, 8'h0F, 8'hC6, 8'h99, 8'h77, 8'hEE};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         step_to(1 + i);
         a_if.uart_we = 1'b1;
         a_if.wr_data = bytes[i];
      end
      step(1);
      a_if.uart_we = 1'b0;
      checks++; if (a_if.level !== 3'd4) begin errors++; $display("FAIL ovf_level: got %0d expected 4", a_if.level); end
      checks++; if (a_if.full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b expected 1", a_if.full); end
      checks++; if (a_if.ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", a_if.ovf); end
      a_if.ovf_clr = 1'b1;
      a_if.uart_we = 1'b1;
      a_if.wr_data = bytes[6];
      step(1);
      a_if.ovf_clr = 1'b0;
      a_if.uart_we = 1'b0;
      checks++; if (a_if.ovf !== 1'b1 || a_if.level !== 3'd4) begin errors++; $display("FAIL ovf_clr_vs_drop: got ovf=%b level=%0d expected ovf=1 level=4", a_if.ovf, a_if.level); end
      step_to(10);
      checks++; if (a_if.level !== 3'd3 || a_if.full !== 1'b0) begin errors++; $display("FAIL ovf_after_pop: got level=%0d full=%b expected level=3 full=0", a_if.level, a_if.full); end
      step_to(12);
      a_if.ovf_clr = 1'b1;
      step(1);
      a_if.ovf_clr = 1'b0;
      checks++; if (a_if.ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", a_if.ovf); end
      for (int k = 0; k < 4 * NA; k++) begin
         step_to(15 + 10 * k);
         e = exp_bit(bytes[k / NA], 8, 1'b0, k % NA);
         checks++; if (a_if.uart_tx !== e || a_if.busy !== 1'b1) begin errors++; $display("FAIL b2b_bit%0d: got tx=%b busy=%b expected tx=%b busy=1", k, a_if.uart_tx, a_if.busy, e); end
      end
      step_to(10 + 40 * NA);
      checks++; if (a_if.busy !== 1'b0 || a_if.level !== 3'd0) begin errors++; $display("FAIL b2b_end: got busy=%b level=%0d expected busy=0 level=0", a_if.busy, a_if.level); end
   endtask

   task automatic test_small_frame();
      logic e;
      do_reset();
      step_to(1);
      b_if.uart_we = 1'b1;
      b_if.wr_data = 8'hFF;
      step(1);
      b_if.uart_we = 1'b0;
      step_to(9);
      checks++; if (b_if.level !== 3'd1) begin errors++; $display("FAIL small_level_c9: got %0d expected 1", b_if.level); end
      b_if.uart_we = 1'b1;
      b_if.wr_data = 8'h0A;
      step(1);
      b_if.uart_we = 1'b0;
      checks++; if (b_if.level !== 3'd1) begin errors++; $display("FAIL small_push_pop: got %0d expected 1", b_if.level); end
      for (int k = 0; k < 2 * NB; k++) begin
         step_to(15 + 10 * k);
         e = exp_bit((k < NB) ? 8'h1F : 8'h0A, 5, 1'b0, k % NB);
         checks++; if (b_if.uart_tx !== e) begin errors++; $display("FAIL small_bit%0d: got %b expected %b", k, b_if.uart_tx, e); end
      end
      step_to(10 + 20 * NB);
      checks++; if (b_if.busy !== 1'b0 || b_if.uart_tx !== 1'b1) begin errors++; $display("FAIL small_end: got busy=%b tx=%b expected busy=0 tx=1", b_if.busy, b_if.uart_tx); end
   endtask

   task automatic test_write_on_tick();
      do_reset();
      step_to(9);
      a_if.uart_we = 1'b1;
      a_if.wr_data = 8'h80;
      step(1);
      a_if.uart_we = 1'b0;
      checks++; if (a_if.level !== 3'd1 || a_if.busy !== 1'b0) begin errors++; $display("FAIL late_write_c10: got level=%0d busy=%b expected level=1 busy=0", a_if.level, a_if.busy); end
      step_to(20);
      checks++; if (a_if.busy !== 1'b1 || a_if.uart_tx !== 1'b0 || a_if.level !== 3'd0) begin errors++; $display("FAIL late_write_c20: got busy=%b tx=%b level=%0d expected 1 0 0", a_if.busy, a_if.uart_tx, a_if.level); end
   endtask

   task automatic test_reset_mid();
      logic quiet;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         step_to(1 + i);
         a_if.uart_we = 1'b1;
         a_if.wr_data = 8'h00;
      end
      step(1);
      a_if.uart_we = 1'b0;
      step_to(35);
      checks++; if (a_if.level !== 3'd2 || a_if.state !== 3'd2) begin errors++; $display("FAIL mid_pre: got level=%0d state=%0d expected level=2 state=2", a_if.level, a_if.state); end
      rst_n = 1'b0;
      a_if.uart_we = 1'b1;
      step(1);
      rst_n = 1'b1;
      a_if.uart_we = 1'b0;
      cyc = 0;
      checks++; if (a_if.uart_tx !== 1'b1 || a_if.busy !== 1'b0 || a_if.level !== 3'd0) begin errors++; $display("FAIL mid_reset: got tx=%b busy=%b level=%0d expected 1 0 0", a_if.uart_tx, a_if.busy, a_if.level); end
      quiet = 1'b1;
      for (int i = 0; i < 300; i++) begin
         step(1);
         if (a_if.uart_tx !== 1'b1 || a_if.busy !== 1'b0) quiet = 1'b0;
      end
      checks++; if (quiet !== 1'b1) begin errors++; $display("FAIL mid_no_frames: got quiet=%b expected 1", quiet); end
   endtask

   initial begin
      rst_n           = 1'b0;
      a_if.wr_data    = '0;
      a_if.uart_we    = 1'b0;
      a_if.parity_odd = 1'b0;
      a_if.ovf_clr    = 1'b0;
      b_if.wr_data    = '0;
      b_if.uart_we    = 1'b0;
      b_if.parity_odd = 1'b0;
      b_if.ovf_clr    = 1'b0;
      step(2);
      test_reset();
      test_frame(1'b0);
      test_frame(1'b1);
      test_overflow();
      test_small_frame();
      test_write_on_tick();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/uart_txq.md
UART_TXQ -- requirements
Module: uart_txq

Interface
REQ-001 Parameter DATA_BITS, default 8: data bits per frame, legal 5..8.
REQ-002 Parameter STOP_BITS, default 2: stop bits per frame, legal 1 or 2.
REQ-003 Parameter FIFO_DEPTH, default 16: transmit queue entries, power of two, 2..256.
REQ-004 Parameter SYSCLK_FREQ, default `SYSCLK_FREQ from define.vh: system clock in Hz.
REQ-005 Parameter BAUD_RATE, default `BAUD_RATE from define.vh: line rate in bit/s, less than SYSCLK_FREQ.
REQ-006 clk  input  1  system clock; all logic on its rising edge.
REQ-007 rst_n  input  1  reset, synchronous, active-low.
REQ-008 wr_data  input  8  byte to enqueue; bits above DATA_BITS-1 ignored.
REQ-009 uart_we  input  1  enqueue strobe, one byte per asserted cycle.
REQ-010 parity_odd  input  1  parity sense, 1 = odd, 0 = even; sampled at frame start.
REQ-011 ovf_clr  input  1  clears the overflow flag.
REQ-012 uart_tx  output  1  serial line, idle high.
REQ-013 busy  output  1  frame in progress (state not IDLE).
REQ-014 full  output  1  FIFO holds FIFO_DEPTH entries.
REQ-015 level  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-016 ovf  output  1  sticky, set when a write is dropped.

Function
REQ-017 Baud generator: accumulator acc, 32 bits; each cycle, if acc+BAUD_RATE >= SYSCLK_FREQ then tick=1 and acc <= acc+BAUD_RATE-SYSCLK_FREQ, else tick=0 and acc <= acc+BAUD_RATE; tick is combinational from acc and runs free.
REQ-018 Write: uart_we with full=0 stores wr_data at the tail; uart_we with full=1 drops the byte and sets ovf, even if a pop occurs in the same cycle.
REQ-019 Write and pop in the same cycle with FIFO non-empty: both are performed and level is unchanged.
REQ-020 A pop never happens when level=0; a byte written in cycle N is poppable no earlier than cycle N+1.
REQ-021 ovf_clr clears ovf; if ovf_clr and a dropped write occur in the same cycle, ovf ends at 1.
REQ-022 FSM states: IDLE, START, DATA, PARITY, STOP; all transitions occur only on cycles with tick=1; the bit value is registered onto uart_tx at that edge.
REQ-023 IDLE with tick and level>0: pop head into shift register, latch parity_odd, uart_tx<=0, go to START.
REQ-024 START on tick: uart_tx<=data[0], go to DATA with bit index 0.
REQ-025 DATA: LSB first; each tick advances the bit index; after bit DATA_BITS-1 go to PARITY (see REQ-034) or STOP with uart_tx<=1.
REQ-026 PARITY on tick: uart_tx<=1, go to STOP.
REQ-027 STOP holds uart_tx=1 for STOP_BITS ticks; on the final tick, if level>0 perform REQ-023 directly (back-to-back frames, no idle bit), else go to IDLE.
REQ-028 Each bit lasts exactly one tick interval; frame length = 1+DATA_BITS+P+STOP_BITS ticks, where P=1 if parity is compiled in, else 0.
REQ-029 busy=1 in every state except IDLE; full=(level==FIFO_DEPTH); FIFO pointers wrap modulo FIFO_DEPTH.

Reset
REQ-030 rst_n=0 at a rising edge forces: uart_tx=1, busy=0, full=0, level=0, ovf=0, acc=0, state=IDLE, FIFO pointers 0.
REQ-031 Reset mid-frame aborts the frame immediately; queued bytes are discarded.
REQ-032 uart_we is ignored in any cycle with rst_n=0.

Configuration
REQ-033 Macro UART_TXQ_PARITY_EN selects parity generation at compile time.
REQ-034 Defined: PARITY state is present; the parity bit = XOR of the DATA_BITS data bits XOR latched parity_odd, sent after the data bits.
REQ-035 Undefined: no PARITY state, DATA goes directly to STOP, and parity_odd is unused.

Verification (SYSCLK_FREQ=10, BAUD_RATE=1: tick at cycles 9, 19, 29, ...)
REQ-036 Parity off, DATA_BITS=8, STOP_BITS=2, write 0x55 at cycle 1 -> uart_tx 0,1,0,1,0,1,0,1,0,1,1 with each bit held 10 cycles starting at cycle 10; then idle high; busy=0 after the 11th bit.
REQ-037 Parity on, parity_odd=0, write 0x55 -> parity bit 0; parity_odd=1 -> parity bit 1; frame is 12 bits.
REQ-038 FIFO_DEPTH=4, write 6 bytes in cycles 1-6 -> level=4, full=1, ovf=1; bytes 1-4 sent back-to-back with no idle gap; ovf_clr -> ovf=0.
REQ-039 DATA_BITS=5, STOP_BITS=1, write 0xFF -> frame 0,1,1,1,1,1,1 (7 bits); wr_data[7:5] ignored.
REQ-040 rst_n low for 1 cycle during the DATA state with 2 bytes queued -> next cycle uart_tx=1, busy=0, level=0; no further frames transmitted.
